// File: rtl/axis_uart_tx_arbiter_if.sv
// AXI-Stream link between the packet arbiter and the UART transmitter.
interface axis_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX stream between NUM_CH
// AXI-Stream requesters. A grant lasts one packet (until tlast), may be
// preceded by a channel-ID header byte, and is dropped if the granted
// channel stays idle for TIMEOUT cycles.
module axis_uart_tx_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADD_HEADER = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clk_i,
    input  logic                           arstn_i,
    input  logic [NUM_CH-1:0]              s_tvalid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata_i,
    input  logic [NUM_CH-1:0]              s_tlast_i,
    output logic [NUM_CH-1:0]              s_tready_o,
    axis_if.master                         m_axis,
    output logic [$clog2(NUM_CH)-1:0]      grant_o,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam int GW    = $clog2(NUM_CH);
    // Counter width must be at least one bit even when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             timeout_q, timeout_d;

    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [GW-1:0]         arb_sel;
    logic [GW-1:0]         cand;
    logic                  arb_hit;
    logic                  gnt_valid;
    logic                  gnt_last;
    logic                  m_hs;

    assign gnt_valid = s_tvalid_i[grant_q];
    assign gnt_last  = s_tlast_i[grant_q];
    assign m_hs      = (state_q == DATA) && gnt_valid && m_axis.tready;

    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = timeout_q;

    // Split the flat tdata bus into one byte per channel.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_data[k] = s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting one past the last served channel.
    always_comb begin
        arb_sel = last_grant_q;
        arb_hit = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = GW'((int'(last_grant_q) + i) % NUM_CH);
            if (!arb_hit && s_tvalid_i[cand]) begin
                arb_sel = cand;
                arb_hit = 1'b1;
            end
        end
    end

    // State register; reset aborts any packet in flight immediately.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_CH - 1);
            idle_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idle_cnt_q   <= idle_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic: arbitration, packet tracking and idle timeout.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        idle_cnt_d   = '0;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    grant_d = arb_sel;
                    state_d = (ADD_HEADER != 0) ? HEADER : DATA;
                end
            end
            HEADER: begin
                if (m_axis.tready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                idle_cnt_d = idle_cnt_q;
                if (m_hs) begin
                    // A handshake always beats a timeout in the same cycle.
                    idle_cnt_d = '0;
                    if (gnt_last) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end else if ((TIMEOUT > 0) && (idle_cnt_q == CNT_TC)) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                    timeout_d    = 1'b1;
                end else if ((TIMEOUT > 0) && !gnt_valid && (idle_cnt_q != CNT_MAX)) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: header byte, then combinational pass-through of the grant.
    always_comb begin
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tlast  = 1'b0;
        s_tready_o    = '0;
        case (state_q)
            HEADER: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = DATA_WIDTH'(grant_q);
            end
            DATA: begin
                m_axis.tvalid       = gnt_valid;
                m_axis.tdata        = ch_data[grant_q];
                m_axis.tlast        = gnt_last;
                s_tready_o[grant_q] = m_axis.tready;
            end
            default: begin
                m_axis.tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench for axis_uart_tx_arbiter: per-channel byte sources,
// an expected-beat queue filled by the test sequence, and a monitor that
// pops and compares on every m_axis handshake.
module tb_axis_uart_tx_arbiter;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic [1:0] g;
    } exp_t;

    logic        clk;
    logic        arstn_i;
    logic [3:0]  s_tvalid_i;
    logic [31:0] s_tdata_i;
    logic [3:0]  s_tlast_i;
    logic [3:0]  s_tready_o;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic        timeout_o;

    axis_if #(.DATA_WIDTH(8)) m_if ();

    axis_uart_tx_arbiter #(
        .NUM_CH     (4),
        .DATA_WIDTH (8),
        .ADD_HEADER (1),
        .TIMEOUT    (16)
    ) dut (
        .clk_i      (clk),
        .arstn_i    (arstn_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tdata_i  (s_tdata_i),
        .s_tlast_i  (s_tlast_i),
        .s_tready_o (s_tready_o),
        .m_axis     (m_if.master),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    beat_t src_q [4][$];
    exp_t  exp_q [$];
    bit    tr_q  [$];
    logic [3:0] hs_pend;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs_cyc = 0;
    int to_cnt = 0;
    int to_gap = 0;
    logic to_busy = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic src(input int ch, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        src_q[ch].push_back(b);
    endtask

    task automatic ex(input logic [7:0] d, input logic l, input logic [1:0] g);
        exp_t e;
        e.d = d;
        e.l = l;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic clear_sources();
        for (int k = 0; k < 4; k++) src_q[k].delete();
        tr_q.delete();
        hs_pend = '0;
    endtask

    task automatic wait_drain(input string nm, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk); #4;
            if (exp_q.size() == 0) done = 1'b1;
        end
        chk({nm, " drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, " m_tvalid"}, m_if.tvalid, 1'b0);
        chk({nm, " s_tready"}, s_tready_o, 4'b0000);
        chk({nm, " grant/busy/timeout"}, {grant_o, busy_o, timeout_o}, 4'b0000);
    endtask

    // Source driver: present each channel's queue head, retire on handshake.
    initial begin
        s_tvalid_i = '0;
        s_tdata_i  = '0;
        s_tlast_i  = '0;
        m_if.tready = 1'b1;
        hs_pend    = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (hs_pend[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            end
            m_if.tready = (tr_q.size() > 0) ? tr_q.pop_front() : 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (src_q[k].size() > 0) begin
                    s_tvalid_i[k]         = 1'b1;
                    s_tdata_i[k*8 +: 8]   = src_q[k][0].d;
                    s_tlast_i[k]          = src_q[k][0].l;
                end else begin
                    s_tvalid_i[k]         = 1'b0;
                    s_tdata_i[k*8 +: 8]   = 8'h00;
                    s_tlast_i[k]          = 1'b0;
                end
            end
            #1;
            hs_pend = s_tvalid_i & s_tready_o;
        end
    end

    // Monitor: compare each m_axis beat against the scoreboard.
    initial begin
        logic       stall_prev;
        logic [9:0] prev_vec;
        exp_t       e;
        stall_prev = 1'b0;
        prev_vec   = '0;
        forever begin
            @(negedge clk); #3;
            cyc++;
            if (!arstn_i) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("held while stalled", {m_if.tvalid, m_if.tlast, m_if.tdata}, prev_vec);
                if (m_if.tvalid && m_if.tready) begin
                    last_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected beat: got data %0h with nothing expected", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat data", m_if.tdata, e.d);
                        chk("beat tlast", m_if.tlast, e.l);
                        chk("beat grant", grant_o, e.g);
                    end
                end
                stall_prev = m_if.tvalid && !m_if.tready;
                prev_vec   = {m_if.tvalid, m_if.tlast, m_if.tdata};
                if (timeout_o) begin
                    to_cnt++;
                    to_gap  = cyc - last_hs_cyc;
                    to_busy = busy_o;
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        arstn_i = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check_reset_state("reset");
        @(negedge clk); #2;
        arstn_i = 1'b1;

        // Single requester ch2: header then two data bytes.
        @(negedge clk); #4;
        src(2, 8'h41, 1'b0); src(2, 8'h42, 1'b1);
        ex(8'h02, 1'b0, 2'd2); ex(8'h41, 1'b0, 2'd2); ex(8'h42, 1'b1, 2'd2);
        wait_drain("ch2 packet", 30);
        @(negedge clk); #4;
        chk("busy after tlast", busy_o, 1'b0);
        chk("grant held in idle", grant_o, 2'd2);

        // Fresh reset, then all four channels compete; ch0 has a second packet.
        @(negedge clk); #2;
        arstn_i = 1'b0;
        clear_sources();
        @(negedge clk); #4;
        check_reset_state("second reset");
        @(negedge clk); #2;
        arstn_i = 1'b1;
        @(negedge clk); #4;
        src(0, 8'hA0, 1'b1); src(0, 8'hB0, 1'b1);
        src(1, 8'hA1, 1'b1); src(2, 8'hA2, 1'b1); src(3, 8'hA3, 1'b1);
        ex(8'h00, 1'b0, 2'd0); ex(8'hA0, 1'b1, 2'd0);
        ex(8'h01, 1'b0, 2'd1); ex(8'hA1, 1'b1, 2'd1);
        ex(8'h02, 1'b0, 2'd2); ex(8'hA2, 1'b1, 2'd2);
        ex(8'h03, 1'b0, 2'd3); ex(8'hA3, 1'b1, 2'd3);
        ex(8'h00, 1'b0, 2'd0); ex(8'hB0, 1'b1, 2'd0);
        wait_drain("round robin", 60);

        // ch1 mid-packet while ch0 and ch3 start requesting; next grant is 3.
        src(1, 8'hC0, 1'b0); src(1, 8'hC1, 1'b0); src(1, 8'hC2, 1'b0); src(1, 8'hC3, 1'b1);
        ex(8'h01, 1'b0, 2'd1); ex(8'hC0, 1'b0, 2'd1); ex(8'hC1, 1'b0, 2'd1);
        ex(8'hC2, 1'b0, 2'd1); ex(8'hC3, 1'b1, 2'd1);
        ex(8'h03, 1'b0, 2'd3); ex(8'hD3, 1'b1, 2'd3);
        ex(8'h00, 1'b0, 2'd0); ex(8'hD0, 1'b1, 2'd0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk); #4;
                if (s_tready_o[1]) seen = 1'b1;
            end
            chk("ch1 data phase reached", seen, 1'b1);
        end
        src(0, 8'hD0, 1'b1); src(3, 8'hD3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #4;
            chk("ready only to ch1", s_tready_o, 4'b0010);
        end
        wait_drain("mid-packet requests", 40);

        // Timeout: ch1 sends one byte without tlast and goes quiet; ch2 waits.
        chk("no timeout yet", to_cnt, 0);
        src(1, 8'h55, 1'b0);
        src(2, 8'h66, 1'b1);
        ex(8'h01, 1'b0, 2'd1); ex(8'h55, 1'b0, 2'd1);
        ex(8'h02, 1'b0, 2'd2); ex(8'h66, 1'b1, 2'd2);
        wait_drain("timeout recovery", 80);
        chk("timeout pulse count", to_cnt, 1);
        chk("timeout cycles after last byte", to_gap, 17);
        chk("idle during timeout pulse", to_busy, 1'b0);

        // Back-pressure: m tready alternates during a 4-byte ch0 packet.
        for (int i = 0; i < 8; i++) begin
            tr_q.push_back(1'b1);
            tr_q.push_back(1'b0);
        end
        src(0, 8'hE0, 1'b0); src(0, 8'hE1, 1'b0); src(0, 8'hE2, 1'b0); src(0, 8'hE3, 1'b1);
        ex(8'h00, 1'b0, 2'd0); ex(8'hE0, 1'b0, 2'd0); ex(8'hE1, 1'b0, 2'd0);
        ex(8'hE2, 1'b0, 2'd0); ex(8'hE3, 1'b1, 2'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #4;
            if (m_if.tvalid && (m_if.tdata[7:4] == 4'hE))
                chk("s_tready[0] mirrors m tready", s_tready_o, {3'b000, m_if.tready});
        end
        wait_drain("back-pressure", 30);

        // Reset during DATA after two of five ch2 bytes.
        for (int i = 0; i < 5; i++) src(2, 8'hF0 + 8'(i), (i == 4));
        ex(8'h02, 1'b0, 2'd2); ex(8'hF0, 1'b0, 2'd2); ex(8'hF1, 1'b0, 2'd2);
        wait_drain("partial packet", 30);
        @(negedge clk); #2;
        arstn_i = 1'b0;
        clear_sources();
        #2;
        chk("abort m_tvalid", m_if.tvalid, 1'b0);
        chk("abort s_tready", s_tready_o, 4'b0000);
        chk("abort busy", busy_o, 1'b0);
        @(negedge clk); #2;
        arstn_i = 1'b1;
        @(negedge clk); #4;
        src(0, 8'h70, 1'b1); src(2, 8'h72, 1'b1);
        ex(8'h00, 1'b0, 2'd0); ex(8'h70, 1'b1, 2'd0);
        ex(8'h02, 1'b0, 2'd2); ex(8'h72, 1'b1, 2'd2);
        wait_drain("after abort", 30);
        repeat (3) @(negedge clk);
        #4;
        chk("final timeout pulse count", to_cnt, 1);
        chk("final idle", busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
